freq_ratio_detector: RTL and testbench
======================================

// Module: freq_ratio_detector
// PURPOSE
//  Receive-side companion to the programmable power-of-two clock divider.
//  Samples the divided square wave on the system clock and measures the run length between edges.
//  Recovers the 3-bit divide select (half period 2^k clk => code k) and reports lock once the code is stable.
//  Sits in the checker path of the divider subsystem for ratio verification and self-test.
// PARAMETERS
//  SEL_W     3   width of recovered code; max code 2^SEL_W-1, MAX_RUN = 2^(2^SEL_W-1) = 128 clk
//  LOCK_CNT  4   consecutive identical valid measurements required to assert locked (>=1)
// PORTS
//  clk         in   1      system clock, same domain as the divider
//  rst         in   1      synchronous reset, active-high
//  div_in      in   1      divided waveform under test (synchronous to clk)
//  sel_out     out  SEL_W  last valid recovered code
//  code_valid  out  1      1-clk pulse: sel_out updated by a new valid measurement
//  locked      out  1      level: LOCK_CNT consecutive equal codes seen, no error since
//  err         out  1      1-clk pulse: malformed run length or timeout
// BEHAVIOUR
//  Reset (rst=1 at posedge clk): sig_q=sig_p=0, run=0, match=0, state=IDLE; all outputs 0 next cycle.
//  Front end: sig_q<=div_in; sig_p<=sig_q; edge = sig_q^sig_p (either polarity).
//  Run counter (8b for SEL_W=3): edge -> run<=0; no edge -> run<=run+1, saturating at MAX_RUN.
//  Run length L = run+1 at an edge cycle. Valid iff L is a power of two and L<=MAX_RUN; code = log2(L).
//  Latency: div_in transition sampled at posedge E -> code_valid/sel_out/err registered at E+1.
//  FSM states IDLE, ACQ, LOCK:
//   IDLE: on edge -> ACQ, run<=0, no measurement (first run after IDLE is unaligned, discarded).
//         No edge -> stay; err never fires in IDLE.
//   ACQ:  valid L -> code_valid=1, sel_out=code.
//         If code==sel_out and match>0, match+1, else match<=1.
//         When match reaches LOCK_CNT -> LOCK.
//         Invalid L -> err=1, match<=0, stay ACQ (this edge is the new reference).
//   LOCK: valid L, same code -> code_valid=1, stay.
//         Valid L, different code -> code_valid=1, sel_out=new code, err=1, match<=1, -> ACQ.
//         Invalid L -> err=1, match<=0, -> ACQ.
//   ACQ/LOCK timeout: no edge and run==MAX_RUN -> err=1, match<=0, -> IDLE.
//         Run holds saturated, so err is a single pulse.
//  Edge on the same cycle run==MAX_RUN: treated as invalid L (edge wins), not timeout.
//  locked = registered (state==LOCK); drops the cycle after any err.
//  LOCK_CNT=1: the first valid measurement from ACQ enters LOCK.
//  rst mid-run: no err/code_valid emitted for the aborted run.
// STRUCTURE
//  freq_div_pkg:
//   - SEL_W default, MAX_RUN localparam
//   - typedef enum {IDLE,ACQ,LOCK} fdet_state_t
//   - function is_pow2 and log2 for run length
//  Sub-module freq_edge_detect:
//   - sig_q/sig_p registers, edge output, saturating run counter
//  Top: FSM, match counter, output registers.
// TESTING
//  1 Divider sel=3 drives div_in:
//    - code_valid every 8 clk with sel_out=3
//    - first run discarded
//    - locked rises 1 clk after 4th pulse
//  2 sel=0 (toggle every clk): code_valid every clk, sel_out=0; locked after 4 measurements.
//  3 sel=7: half period 128 exactly -> sel_out=7, code_valid every 128 clk, never err/timeout.
//  4 Locked at sel=2, switch divider to sel=5:
//    - err pulse(s) on transition run(s), locked=0
//    - relock with sel_out=5 after 4 equal runs
//  5 Lock at sel=4, then hold div_in constant:
//    - err exactly once, 128 clk after last edge
//    - locked=0, FSM IDLE, no further err
//  6 Forced runs of 6 and 3 clk -> err each, no code_valid.
//    rst mid-run -> all outputs 0 next clk, first post-reset run discarded.

Source files
------------

// File: rtl/freq_div_pkg.sv
// Shared definitions for the power-of-two divider checker path.
// Provides the default code width, the derived maximum run length,
// the detector FSM state type and run-length helper functions.
package freq_div_pkg;

    localparam int unsigned SEL_W_DEF = 3;
    // Largest half period the divider can produce: 2^(2^SEL_W-1) clk.
    localparam int unsigned MAX_RUN   = 1 << ((1 << SEL_W_DEF) - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2
    } fdet_state_t;

    function automatic int unsigned max_run_for(input int unsigned sel_w);
        return 1 << ((1 << sel_w) - 1);
    endfunction

    function automatic logic is_pow2(input int unsigned len);
        return (len != 0) && ((len & (len - 1)) == 0);
    endfunction

    // Index of the highest set bit; only meaningful for powers of two.
    function automatic int unsigned len_log2(input int unsigned len);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (len[i]) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/freq_edge_detect.sv
// Front end of the ratio detector: registers the divided waveform,
// flags either-polarity transitions and counts clocks since the last one.
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   div_in     divided waveform (synchronous to clk)
//   edge_seen  high for one cycle after a transition reaches sig_q
//   run        clocks since the last edge, saturating at MAX_RUN_P
module freq_edge_detect #(
    parameter int unsigned RUN_W     = 8,
    parameter int unsigned MAX_RUN_P = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_in,
    output logic             edge_seen,
    output logic [RUN_W-1:0] run
);

    logic sig_q;
    logic sig_p;

    assign edge_seen = sig_q ^ sig_p;

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= 1'b0;
            sig_p <= 1'b0;
            run   <= '0;
        end else begin
            sig_q <= div_in;
            sig_p <= sig_q;
            if (edge_seen) begin
                run <= '0;
            end else if (run != RUN_W'(MAX_RUN_P)) begin
                // Saturation keeps a stalled input from wrapping into a
                // plausible-looking run length.
                run <= run + 1'b1;
            end
        end
    end

endmodule

// File: rtl/freq_ratio_detector.sv
// Recovers the divide select of a power-of-two clock divider from its
// output waveform and reports lock once the recovered code is stable.
// Ports:
//   clk, rst    system clock, synchronous active-high reset
//   div_in      divided waveform under test
//   sel_out     last valid recovered code (half period 2^sel_out clk)
//   code_valid  one-cycle pulse: sel_out was just written by a valid run
//   locked      level: LOCK_CNT equal codes seen with no error since
//   err         one-cycle pulse: malformed run length or timeout
//   state_dbg   current FSM state, for observation only
// Output semantics: code_valid and err are unconditional pulses with no
// back-pressure; a consumer must capture sel_out on the code_valid cycle.
module freq_ratio_detector
    import freq_div_pkg::*;
#(
    parameter int unsigned SEL_W    = SEL_W_DEF,
    parameter int unsigned LOCK_CNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_in,
    output logic [SEL_W-1:0] sel_out,
    output logic             code_valid,
    output logic             locked,
    output logic             err,
    output fdet_state_t      state_dbg
);

    localparam int unsigned MAX_CODE = (1 << SEL_W) - 1;
    localparam int unsigned RUN_MAX  = max_run_for(SEL_W);
    localparam int unsigned RUN_W    = MAX_CODE + 1;
    // One spare bit so the increment past LOCK_CNT=1 cannot wrap.
    localparam int unsigned MATCH_W  = $clog2(LOCK_CNT + 1) + 1;

    logic               edge_seen;
    logic [RUN_W-1:0]   run;

    freq_edge_detect #(
        .RUN_W     (RUN_W),
        .MAX_RUN_P (RUN_MAX)
    ) u_edge (
        .clk       (clk),
        .rst       (rst),
        .div_in    (div_in),
        .edge_seen (edge_seen),
        .run       (run)
    );

    fdet_state_t        state, state_n;
    logic [MATCH_W-1:0] match, match_n, match_inc;
    logic [SEL_W-1:0]   sel_n;
    logic               code_valid_n;
    logic               err_n;

    logic [RUN_W:0]     run_len;
    logic               len_ok;
    logic [SEL_W-1:0]   len_code;
    logic               run_full;

    // Length of the run ending at this edge; a saturated counter yields
    // MAX_RUN+1, which fails the range check, so an edge there is invalid.
    assign run_len  = {1'b0, run} + 1'b1;
    assign len_ok   = is_pow2(32'(run_len)) && (32'(run_len) <= RUN_MAX);
    assign len_code = SEL_W'(len_log2(32'(run_len)));
    assign run_full = (run == RUN_W'(RUN_MAX));

    assign match_inc = ((len_code == sel_out) && (match != '0)) ?
                       match + 1'b1 : MATCH_W'(1);

    always_comb begin
        state_n      = state;
        match_n      = match;
        sel_n        = sel_out;
        code_valid_n = 1'b0;
        err_n        = 1'b0;
        case (state)
            IDLE: begin
                // The run ending here started at an unknown point: discard.
                if (edge_seen) state_n = ACQ;
            end
            ACQ, LOCK: begin
                if (edge_seen) begin
                    if (len_ok) begin
                        code_valid_n = 1'b1;
                        sel_n        = len_code;
                        if (state == ACQ) begin
                            match_n = match_inc;
                            if (match_inc >= MATCH_W'(LOCK_CNT)) state_n = LOCK;
                        end else if (len_code != sel_out) begin
                            err_n   = 1'b1;
                            match_n = MATCH_W'(1);
                            state_n = ACQ;
                        end
                    end else begin
                        err_n   = 1'b1;
                        match_n = '0;
                        state_n = ACQ;
                    end
                end else if (run_full) begin
                    err_n   = 1'b1;
                    match_n = '0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            match      <= '0;
            sel_out    <= '0;
            code_valid <= 1'b0;
            err        <= 1'b0;
            locked     <= 1'b0;
        end else begin
            state      <= state_n;
            match      <= match_n;
            sel_out    <= sel_n;
            code_valid <= code_valid_n;
            err        <= err_n;
            locked     <= (state == LOCK);
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_freq_ratio_detector.sv
// Directed bench for freq_ratio_detector. Each table record describes one
// run: hold div_in for len clocks, then toggle, and what the detector must
// report two clocks after that toggle. Expected levels are written into
// per-cycle arrays which a monitor compares every cycle, so spurious
// pulses between records are caught too.
module tb_freq_ratio_detector;
    import freq_div_pkg::*;

    localparam int N = 4096;

    logic        clk;
    logic        rst;
    logic        div_in;
    logic [2:0]  sel_out;
    logic        code_valid;
    logic        locked;
    logic        err;
    fdet_state_t state_dbg;

    freq_ratio_detector #(
        .SEL_W    (3),
        .LOCK_CNT (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .div_in     (div_in),
        .sel_out    (sel_out),
        .code_valid (code_valid),
        .locked     (locked),
        .err        (err),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock / reset / cycle count ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #60000;
        $display("FAIL watchdog: cycle %0d reached, required finish earlier", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    bit exp_cv   [N];
    bit exp_err  [N];
    bit exp_lock [N];
    int exp_sel  [N];

    int vec_cnt  = 0;
    int miss_cnt = 0;
    bit mon_en   = 1'b0;
    int last_t   = 0;

    task automatic check(input string name, input int act, input int exp);
        vec_cnt++;
        if (act != exp) begin
            miss_cnt++;
            $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (mon_en && cyc < N) begin
            check("code_valid", int'(code_valid), int'(exp_cv[cyc]));
            check("err",        int'(err),        int'(exp_err[cyc]));
            check("locked",     int'(locked),     int'(exp_lock[cyc]));
            check("sel_out",    int'(sel_out),    exp_sel[cyc]);
        end
    end

    // ---------------- driver tasks ----------------
    typedef struct {
        int len;
        bit cv;
        int sel;
        bit er;
        bit lk;
    } vec_t;

    vec_t tbl[$];

    task automatic add_vec(input int len, input bit cv, input int sel,
                           input bit er, input bit lk);
        vec_t v;
        v.len = len; v.cv = cv; v.sel = sel; v.er = er; v.lk = lk;
        tbl.push_back(v);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called at #1 after a posedge; toggles len clocks after the last toggle.
    task automatic run_then_toggle(input vec_t v);
        int t;
        while (cyc < last_t + v.len) begin
            @(posedge clk);
            #1;
        end
        div_in = ~div_in;
        t = cyc;
        last_t = t;
        if (t + 3 < N) begin
            exp_cv[t+2]  = v.cv;
            exp_err[t+2] = v.er;
            if (v.cv) for (int c = t + 2; c < N; c++) exp_sel[c] = v.sel;
            for (int c = t + 3; c < N; c++) exp_lock[c] = v.lk;
        end
    endtask

    task automatic apply_reset();
        int n;
        rst    = 1'b1;
        div_in = 1'b0;
        n = cyc;
        for (int c = n + 1; c < N; c++) begin
            exp_cv[c]   = 1'b0;
            exp_err[c]  = 1'b0;
            exp_lock[c] = 1'b0;
            exp_sel[c]  = 0;
        end
        wait_cycles(1);
        rst = 1'b0;
        last_t = cyc;
    endtask

    // ---------------- test ----------------
    initial begin
        vec_t v;
        int t_err;

        for (int c = 0; c < N; c++) begin
            exp_cv[c] = 0; exp_err[c] = 0; exp_lock[c] = 0; exp_sel[c] = 0;
        end

        // sel=3, half period 8: first run discarded, lock after 4th pulse
        add_vec(5,   0, 0, 0, 0);
        add_vec(8,   1, 3, 0, 0);
        add_vec(8,   1, 3, 0, 0);
        add_vec(8,   1, 3, 0, 0);
        add_vec(8,   1, 3, 0, 1);
        add_vec(8,   1, 3, 0, 1);
        // sel=0, toggle every clk: code change from LOCK flags err
        add_vec(1,   1, 0, 1, 0);
        add_vec(1,   1, 0, 0, 0);
        add_vec(1,   1, 0, 0, 0);
        add_vec(1,   1, 0, 0, 1);
        add_vec(1,   1, 0, 0, 1);
        // sel=7, half period 128 exactly: valid, no timeout
        add_vec(128, 1, 7, 1, 0);
        add_vec(128, 1, 7, 0, 0);
        add_vec(128, 1, 7, 0, 0);
        add_vec(128, 1, 7, 0, 1);
        add_vec(128, 1, 7, 0, 1);
        // lock at sel=2, then switch divider to sel=5 and relock
        add_vec(4,   1, 2, 1, 0);
        add_vec(4,   1, 2, 0, 0);
        add_vec(4,   1, 2, 0, 0);
        add_vec(4,   1, 2, 0, 1);
        add_vec(4,   1, 2, 0, 1);
        add_vec(32,  1, 5, 1, 0);
        add_vec(32,  1, 5, 0, 0);
        add_vec(32,  1, 5, 0, 0);
        add_vec(32,  1, 5, 0, 1);
        // edge on the saturated cycle: invalid length, not a timeout
        add_vec(129, 0, 5, 1, 0);
        add_vec(2,   1, 1, 0, 0);
        // malformed runs 6 and 3: err, no code_valid
        add_vec(6,   0, 1, 1, 0);
        add_vec(3,   0, 1, 1, 0);
        // reacquire at sel=4
        add_vec(16,  1, 4, 0, 0);
        add_vec(16,  1, 4, 0, 0);
        add_vec(16,  1, 4, 0, 0);
        add_vec(16,  1, 4, 0, 1);

        rst    = 1'b1;
        div_in = 1'b0;
        wait_cycles(3);
        rst    = 1'b0;
        mon_en = 1'b1;
        last_t = cyc;

        for (int i = 0; i < tbl.size(); i++) begin
            run_then_toggle(tbl[i]);
        end

        // Timeout from LOCK: single err, then IDLE with no further err
        t_err = last_t + 131;
        exp_err[t_err] = 1'b1;
        for (int c = t_err + 1; c < N; c++) exp_lock[c] = 1'b0;
        wait_cycles(10);
        check("state_locked", int'(state_dbg), int'(LOCK));
        while (cyc < last_t + 160) wait_cycles(1);
        check("state_idle_after_timeout", int'(state_dbg), int'(IDLE));

        // From IDLE the first run is discarded, the next one is measured
        last_t = cyc;
        v.len = 3;  v.cv = 0; v.sel = 4; v.er = 0; v.lk = 0;
        run_then_toggle(v);
        v.len = 16; v.cv = 1; v.sel = 4; v.er = 0; v.lk = 0;
        run_then_toggle(v);

        // Reset in the middle of a run: outputs clear, nothing emitted
        wait_cycles(5);
        apply_reset();
        check("state_after_reset", int'(state_dbg), int'(IDLE));
        wait_cycles(2);
        v.len = 4;  v.cv = 0; v.sel = 0; v.er = 0; v.lk = 0;
        run_then_toggle(v);
        v.len = 8;  v.cv = 1; v.sel = 3; v.er = 0; v.lk = 0;
        run_then_toggle(v);
        wait_cycles(6);

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
